// File: rtl/sb_pkg.sv
// Shared constants, state encodings and slot helpers for the superblock
// eviction unpacker.
package sb_pkg;

  localparam int TAG_W    = 21;
  localparam int INDEX_W  = 3;
  localparam int BID_W    = 2;
  localparam int OFFSET_W = 6;
  localparam int LINE_W   = 512;
  localparam int SBTAG_W  = 27;

  localparam int TAG_MSB = 26;
  localparam int TAG_LSB = 6;
  localparam int CF_MSB  = 5;
  localparam int CF_LSB  = 4;

  localparam logic [1:0] CF_NONE    = 2'b00;
  localparam logic [1:0] CF_HALF    = 2'b01;
  localparam logic [1:0] CF_QUARTER = 2'b10;
  localparam logic [1:0] CF_ILLEGAL = 2'b11;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_EMIT = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  typedef logic [1:0] slot_w_t;
  localparam slot_w_t SW_512 = 2'd0;
  localparam slot_w_t SW_256 = 2'd1;
  localparam slot_w_t SW_128 = 2'd2;

  function automatic logic [1:0] lowest_slot(
    input logic [3:0] m
  );
    logic [1:0] k;
    if (m[0])      k = 2'd0;
    else if (m[1]) k = 2'd1;
    else if (m[2]) k = 2'd2;
    else           k = 2'd3;
    return k;
  endfunction

  // Narrow slots are zero-extended into the low end of the line.
  function automatic logic [LINE_W-1:0] slot_line(
    input logic [LINE_W-1:0] d,
    input slot_w_t           w,
    input logic [1:0]        k
  );
    logic [LINE_W-1:0] r;
    r = '0;
    case (w)
      SW_256: r[255:0] = k[0] ? d[511:256] : d[255:0];
      SW_128: r[127:0] = d[{k, 7'b0} +: 128];
      default: r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sb_slot_decode.sv
// Superblock format decode: CF and block field -> slot valid mask,
// per-slot block ids and slot width.
module sb_slot_decode
  import sb_pkg::*;
(
  input  logic [CF_MSB:0] fmt,
  output logic [3:0]      valid,
  output logic [7:0]      bids,
  output slot_w_t         width,
  output logic            illegal
);

  logic [1:0] cf;
  logic [3:0] blk;

  assign cf  = fmt[CF_MSB:CF_LSB];
  assign blk = fmt[3:0];

  always_comb begin
    valid   = 4'b0000;
    bids    = 8'h00;
    width   = SW_512;
    illegal = 1'b0;
    unique case (cf)
      CF_NONE: begin
        valid     = 4'b0001;
        bids[1:0] = blk[3:2];
      end
      CF_HALF: begin
        // Equal ids mark an empty upper half.
        valid     = {2'b00, blk[3:2] != blk[1:0], 1'b1};
        bids[1:0] = blk[1:0];
        bids[3:2] = blk[3:2];
        width     = SW_256;
      end
      CF_QUARTER: begin
        valid = blk;
        bids  = 8'b11_10_01_00;
        width = SW_128;
      end
      CF_ILLEGAL: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/sb_evict_unpacker.sv
// Unpacks one evicted superblock into 64B write-back lines, lowest slot first.
// Optional SBU_DIRTY_MASK_EN: only dirty slots are written back.
module sb_evict_unpacker
  import sb_pkg::*;
(
  input  logic               clock,
  input  logic               reset_n,
  input  logic               evict_valid,
  output logic               evict_ready,
  input  logic [SBTAG_W-1:0] evict_sbtag,
  input  logic [INDEX_W-1:0] evict_index,
  input  logic [LINE_W-1:0]  evict_data,
`ifdef SBU_DIRTY_MASK_EN
  input  logic [3:0]         evict_dirty,
`endif
  output logic               wb_valid,
  input  logic               wb_ready,
  output logic [31:0]        wb_addr,
  output logic [LINE_W-1:0]  wb_data,
  output logic               done,
  output logic               err
);

  state_t              state_q, state_d;
  logic [3:0]          pend_q, pend_d;
  logic [1:0]          cur_q, cur_d;
  logic [LINE_W-1:0]   data_q, data_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic [INDEX_W-1:0]  idx_q, idx_d;
  logic [7:0]          bid_q, bid_d;
  slot_w_t             w_q, w_d;
  logic                wb_valid_q, wb_valid_d;
  logic [31:0]         wb_addr_q, wb_addr_d;
  logic [LINE_W-1:0]   wb_data_q, wb_data_d;
  logic                err_q, err_d;

  logic [3:0]          dec_valid;
  logic [7:0]          dec_bids;
  slot_w_t             dec_w;
  logic                dec_ill;

  sb_slot_decode u_dec (
    .fmt     (evict_sbtag[CF_MSB:0]),
    .valid   (dec_valid),
    .bids    (dec_bids),
    .width   (dec_w),
    .illegal (dec_ill)
  );

  logic              idle, hs;
  logic [3:0]        new_mask, sel_mask;
  logic [1:0]        sel_k;
  logic [LINE_W-1:0] src_data;
  logic [TAG_W-1:0]  src_tag;
  logic [INDEX_W-1:0] src_idx;
  logic [7:0]        src_bids;
  slot_w_t           src_w;
  logic [31:0]       nxt_addr;
  logic [LINE_W-1:0] nxt_line;

  assign idle = (state_q == ST_IDLE);
  assign hs   = wb_valid_q & wb_ready;

`ifdef SBU_DIRTY_MASK_EN
  assign new_mask = dec_valid & evict_dirty;
`else
  assign new_mask = dec_valid;
`endif

  // One selector serves both the first slot on accept and the
  // follow-on slot on handshake, so there is no bubble.
  always_comb begin
    sel_mask = idle ? new_mask : (pend_q & ~(4'b0001 << cur_q));
    sel_k    = lowest_slot(sel_mask);
    src_data = idle ? evict_data : data_q;
    src_tag  = idle ? evict_sbtag[TAG_MSB:TAG_LSB] : tag_q;
    src_idx  = idle ? evict_index : idx_q;
    src_bids = idle ? dec_bids : bid_q;
    src_w    = idle ? dec_w : w_q;
    nxt_addr = {src_tag, src_idx, src_bids[{sel_k, 1'b0} +: 2],
                {OFFSET_W{1'b0}}};
    nxt_line = slot_line(src_data, src_w, sel_k);
  end

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    cur_d      = cur_q;
    data_d     = data_q;
    tag_d      = tag_q;
    idx_d      = idx_q;
    bid_d      = bid_q;
    w_d        = w_q;
    wb_valid_d = wb_valid_q;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    err_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (evict_valid) begin
          if (dec_ill) begin
            err_d = 1'b1;
          end else begin
            data_d = evict_data;
            tag_d  = evict_sbtag[TAG_MSB:TAG_LSB];
            idx_d  = evict_index;
            bid_d  = dec_bids;
            w_d    = dec_w;
            pend_d = new_mask;
            if (new_mask == 4'b0000) begin
              state_d = ST_DONE;
            end else begin
              state_d    = ST_EMIT;
              cur_d      = sel_k;
              wb_valid_d = 1'b1;
              wb_addr_d  = nxt_addr;
              wb_data_d  = nxt_line;
            end
          end
        end
      end
      ST_EMIT: begin
        if (hs) begin
          pend_d = sel_mask;
          if (sel_mask == 4'b0000) begin
            wb_valid_d = 1'b0;
            state_d    = ST_DONE;
          end else begin
            cur_d     = sel_k;
            wb_addr_d = nxt_addr;
            wb_data_d = nxt_line;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      pend_q     <= 4'b0000;
      cur_q      <= 2'd0;
      data_q     <= '0;
      tag_q      <= '0;
      idx_q      <= '0;
      bid_q      <= 8'h00;
      w_q        <= SW_512;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= 32'h0;
      wb_data_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      cur_q      <= cur_d;
      data_q     <= data_d;
      tag_q      <= tag_d;
      idx_q      <= idx_d;
      bid_q      <= bid_d;
      w_q        <= w_d;
      wb_valid_q <= wb_valid_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      err_q      <= err_d;
    end
  end

  assign evict_ready = idle;
  assign done        = (state_q == ST_DONE);
  assign err         = err_q;
  assign wb_valid    = wb_valid_q;
  assign wb_addr     = wb_addr_q;
  assign wb_data     = wb_data_q;

endmodule
